// File: rtl/instruction_fetch.sv
// instruction_fetch - front stage of the rv32i core.
// Owns the PC and issues one word fetch at a time to instruction memory
// over a request valid/ready channel plus a response-valid channel. It then
// hands {instr, pc} to the decoder with a valid/ready handshake.
// A redirect from execute replaces the PC. If a fetch is still in flight,
// the response is drained and discarded.
// Optional feature: define IF_MISALIGN_CHECK_EN to trap redirects whose
// target is not word aligned. A trapped redirect parks the stage in a
// sticky fault state that only rst_n clears. When the macro is not defined,
// the low two target bits are cleared and fetch_fault is tied low.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        id_valid_r;
    logic [31:0] id_instr_r;
    logic [31:0] id_pc_r;

    logic [31:0] redirect_target_s;
    logic        redirect_fault_s;
    logic        redirect_take_s;
    logic        req_valid_s;

    // Clear the byte-offset bits of an address so that it is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Next sequential fetch address. This wraps modulo 2^32.
    function automatic logic [31:0] pc_advance(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // A target is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Redirect target and fault decision for the incoming redirect.
    always_comb begin
`ifdef IF_MISALIGN_CHECK_EN
        redirect_target_s = redirect_pc;
        redirect_fault_s  = is_misaligned(redirect_pc);
`else
        redirect_target_s = word_align(redirect_pc);
        redirect_fault_s  = 1'b0;
`endif
    end

    // Redirects are honoured everywhere except the post-reset idle cycle
    // and the fault state.
    assign redirect_take_s = redirect_valid &&
                             (state_r != S_IDLE) && (state_r != S_FAULT);

    // The request is a function of state and redirect_valid only. It has
    // no path from id_ready, and a redirect cycle never issues a request.
    assign req_valid_s    = (state_r == S_REQ) && !redirect_valid;
    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_r;
    assign id_valid       = id_valid_r;
    assign id_instr       = id_instr_r;
    assign id_pc          = id_pc_r;

`ifdef IF_MISALIGN_CHECK_EN
    logic fetch_fault_r;
    assign fetch_fault = fetch_fault_r;
`else
    assign fetch_fault = 1'b0;
`endif

    // Fetch FSM: the PC, the decoder-facing registers and the sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= 32'h0000_0000;
`ifdef IF_MISALIGN_CHECK_EN
            fetch_fault_r <= 1'b0;
`endif
        end else if (redirect_take_s) begin
            // A redirect beats every other event. Any held instruction is
            // dropped, even one that the decoder accepts in this same cycle.
            pc_r       <= redirect_target_s;
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
            if (redirect_fault_s) begin
                state_r <= S_FAULT;
`ifdef IF_MISALIGN_CHECK_EN
                fetch_fault_r <= 1'b1;
`endif
            end else begin
                case (state_r)
                    // A request is still outstanding unless its response
                    // lands in this same cycle. If it does, that response is
                    // simply dropped.
                    S_WAIT, S_DRAIN: state_r <= imem_resp_valid ? S_REQ : S_DRAIN;
                    default:         state_r <= S_REQ;
                endcase
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_REQ;
                end
                S_REQ: begin
                    if (req_valid_s && imem_req_ready) begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        id_instr_r <= imem_resp_data;
                        id_pc_r    <= pc_r;
                        id_valid_r <= 1'b1;
                        pc_r       <= pc_advance(pc_r);
                        state_r    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        id_valid_r <= 1'b0;
                        id_instr_r <= NOP_INSTR;
                        state_r    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    // A stale response is discarded without touching id_*.
                    if (imem_resp_valid) begin
                        state_r <= S_REQ;
                    end
                end
                S_FAULT: begin
                    // Parked until reset. Late responses are ignored.
                    id_valid_r <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch - self-checking bench for instruction_fetch.
// The bench models memory as one outstanding request with a random
// response delay. A transaction-level scoreboard tracks three things: the
// next program-order address, the live in-flight fetch, and the instruction
// that the decoder should currently see. Directed sequences cover the main
// scenarios. A second instance with RESET_PC = 0xFFFF_FFFC covers the
// PC wrap-around. Honours IF_MISALIGN_CHECK_EN in the same way as the design.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data;
    logic        id_valid, id_ready, redirect_valid, fetch_fault;
    logic [31:0] id_instr, id_pc, redirect_pc;

    logic        w_imem_req_valid, w_imem_req_ready, w_imem_resp_valid;
    logic [31:0] w_imem_addr, w_imem_resp_data;
    logic        w_id_valid, w_id_ready, w_redirect_valid, w_fetch_fault;
    logic [31:0] w_id_instr, w_id_pc, w_redirect_pc;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .id_valid(id_valid),
        .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_imem_req_valid), .imem_req_ready(w_imem_req_ready),
        .imem_addr(w_imem_addr), .imem_resp_valid(w_imem_resp_valid),
        .imem_resp_data(w_imem_resp_data), .id_valid(w_id_valid),
        .id_ready(w_id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .fetch_fault(w_fetch_fault)
    );

    int checks_run    = 0;
    int checks_failed = 0;

    // Stimulus controls, set by the test sequences.
    logic        rd_v = 1'b0, id_rdy = 1'b0, rq_rdy = 1'b0;
    logic [31:0] rd_pc = 32'h0;
    int          next_delay = 0;
    logic        late_resp = 1'b0, idle_flag = 1'b0;

    // Memory model and scoreboard.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic        live = 1'b0, held = 1'b0, faulted = 1'b0;
    logic [31:0] inflight = 32'h0, held_pc = 32'h0, held_instr = 32'h0;
    int          presented = 0;
    logic        acc2_prev = 1'b0;

    // Values sampled in the current cycle.
    logic        s_req, s_idv, s_fault, s2_req, s2_idv;
    logic [31:0] s_addr, s_idpc, s_instr, s2_addr, s2_idpc, s2_instr;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_run++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef IF_MISALIGN_CHECK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    // Runs one clock cycle. It starts and ends at a falling edge.
    task automatic step();
        logic rv, resp, acc, cons, redir, exp_req;
        rv   = idle_flag ? 1'b0 : rd_v;
        resp = (mem_busy && mem_cnt == 0) || (idle_flag && late_resp);
        redirect_valid  = rv;
        redirect_pc     = rd_pc;
        id_ready        = id_rdy;
        imem_req_ready  = rq_rdy;
        imem_resp_valid = resp;
        imem_resp_data  = mem_busy ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        w_imem_req_ready  = 1'b1;
        w_id_ready        = 1'b1;
        w_redirect_valid  = 1'b0;
        w_redirect_pc     = 32'h0;
        w_imem_resp_valid = acc2_prev;
        w_imem_resp_data  = 32'hA5A5_0001;
        #1;
        s_req = imem_req_valid; s_addr = imem_addr; s_idv = id_valid;
        s_idpc = id_pc; s_instr = id_instr; s_fault = fetch_fault;
        s2_req = w_imem_req_valid; s2_addr = w_imem_addr; s2_idv = w_id_valid;
        s2_idpc = w_id_pc; s2_instr = w_id_instr;

        exp_req = !idle_flag && !mem_busy && !held && !rv && !faulted;
        check_value("req_valid", s_req, exp_req);
        if (exp_req) check_value("req_addr", s_addr, exp_pc);
        check_value("id_valid", s_idv, held);
        if (held) begin
            check_value("id_pc", s_idpc, held_pc);
            check_value("id_instr", s_instr, held_instr);
        end else begin
            check_value("id_instr_nop", s_instr, NOP);
        end
        check_value("fetch_fault", s_fault, faulted);

        acc   = s_req && rq_rdy;
        cons  = held && id_rdy;
        redir = rv && !faulted;
        @(posedge clk);
        if (resp) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1; mem_addr = s_addr; mem_cnt = next_delay;
        end
        if (redir) begin
            live = 1'b0; held = 1'b0; exp_pc = eff_target(rd_pc);
`ifdef IF_MISALIGN_CHECK_EN
            if (rd_pc[1:0] != 2'b00) faulted = 1'b1;
`endif
        end else begin
            if (cons) begin held = 1'b0; presented++; end
            if (resp && live) begin
                held = 1'b1; held_pc = inflight; held_instr = mem_word(inflight); live = 1'b0;
            end
        end
        if (acc) begin live = 1'b1; inflight = s_addr; exp_pc = s_addr + 32'd4; end
        acc2_prev = s2_req;
        idle_flag = 1'b0;
        @(negedge clk);
    endtask

    // Applies reset asynchronously, checks the reset values, and releases at a falling edge.
    task automatic do_reset(input logic late);
        rst_n = 1'b0;
        rd_v = 1'b0; id_rdy = 1'b0; rq_rdy = 1'b0;
        redirect_valid = 1'b0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
        w_imem_resp_valid = 1'b0;
        #1;
        check_value("rst_req_valid", imem_req_valid, 1'b0);
        check_value("rst_addr", imem_addr, 32'h0);
        check_value("rst_id_valid", id_valid, 1'b0);
        check_value("rst_id_instr", id_instr, NOP);
        check_value("rst_id_pc", id_pc, 32'h0);
        check_value("rst_fault", fetch_fault, 1'b0);
        check_value("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        check_value("rst_wrap_fault", w_fetch_fault, 1'b0);
        mem_busy = 1'b0; live = 1'b0; held = 1'b0; faulted = 1'b0;
        exp_pc = 32'h0; acc2_prev = 1'b0;
        late_resp = late; idle_flag = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Global time bound so that the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main test sequence.
    initial begin
        rst_n = 1'b0;
        redirect_pc = 32'h0; id_ready = 1'b0; imem_resp_data = 32'h0;
        w_imem_req_ready = 1'b0; w_id_ready = 1'b0; w_redirect_valid = 1'b0;
        w_redirect_pc = 32'h0; w_imem_resp_data = 32'h0;
        @(negedge clk);
        do_reset(1'b0);

        // Basic fetch; the wrap instance runs in lockstep.
        rq_rdy = 1'b1; id_rdy = 1'b1; next_delay = 0;
        step();                                   // c0 idle
        check_value("t1_idle_req", s_req, 1'b0);
        step();                                   // c1 request
        check_value("t1_req", s_req, 1'b1);
        check_value("t1_addr", s_addr, 32'h0);
        check_value("wrap_req_addr", s2_addr, 32'hFFFF_FFFC);
        step();                                   // c2 response
        step();                                   // c3 present
        check_value("t1_valid", s_idv, 1'b1);
        check_value("t1_pc", s_idpc, 32'h0);
        check_value("t1_instr", s_instr, 32'h0050_0093);
        check_value("wrap_valid", s2_idv, 1'b1);
        check_value("wrap_pc", s2_idpc, 32'hFFFF_FFFC);
        check_value("wrap_instr", s2_instr, 32'hA5A5_0001);
        id_rdy = 1'b0;
        step();                                   // c4 next request
        check_value("t1_next_addr", s_addr, 32'h4);
        check_value("wrap_next_req", s2_req, 1'b1);
        check_value("wrap_next_addr", s2_addr, 32'h0);

        // Backpressure for five cycles.
        step();                                   // c5 response
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("bp_valid", s_idv, 1'b1);
            check_value("bp_pc", s_idpc, 32'h4);
            check_value("bp_instr", s_instr, mem_word(32'h4));
            check_value("bp_req", s_req, 1'b0);
        end
        id_rdy = 1'b1;
        step();                                   // c11 consumed
        next_delay = 2;
        step();                                   // c12 request pc 8
        check_value("bp_after_addr", s_addr, 32'h8);
        check_value("bp_after_req", s_req, 1'b1);

        // Redirect in WAIT; the stale response arrives two cycles later.
        rd_v = 1'b1; rd_pc = 32'h100;
        step();                                   // c13 redirect
        rd_v = 1'b0; next_delay = 0;
        step();                                   // c14 drain
        check_value("drain_req", s_req, 1'b0);
        step();                                   // c15 stale response
        check_value("drain_valid", s_idv, 1'b0);
        step();                                   // c16 request
        check_value("redir_addr", s_addr, 32'h100);
        check_value("redir_req", s_req, 1'b1);
        step();                                   // c17 response

        // Redirect in HOLD with id_ready high in the same cycle.
        rd_v = 1'b1; rd_pc = 32'h40; id_rdy = 1'b1;
        step();                                   // c18
        check_value("hold_pc_before", s_idpc, 32'h100);
        rd_v = 1'b0;
        step();                                   // c19
        check_value("hold_drop_valid", s_idv, 1'b0);
        check_value("hold_redir_addr", s_addr, 32'h40);
        step();                                   // c20 response
        step();                                   // c21
        check_value("hold_new_pc", s_idpc, 32'h40);

        // Randomised traffic with occasional resets in the middle of a transaction.
        for (int i = 0; i < 4000; i++) begin
            rq_rdy = ($urandom_range(0, 3) != 0);
            id_rdy = ($urandom_range(0, 2) != 0);
            rd_v   = ($urandom_range(0, 9) == 0);
            rd_pc  = $urandom_range(0, 1023);
            if ($urandom_range(0, 15) == 0) rd_pc = rd_pc | 32'hFFFF_FC00;
`ifdef IF_MISALIGN_CHECK_EN
            rd_pc = rd_pc & 32'hFFFF_FFFC;
`endif
            next_delay = $urandom_range(0, 3);
            if (i % 700 == 350) do_reset(mem_busy);
            step();
        end
        check_value("progress", (presented > 200) ? 32'd1 : 32'd0, 32'd1);

        // Redirect to a misaligned target.
        do_reset(1'b0);
        rq_rdy = 1'b1; id_rdy = 1'b1; next_delay = 0; rd_v = 1'b0;
        step(); step();                           // idle, request 0
        rd_v = 1'b1; rd_pc = 32'h102;
        step();                                   // redirect while the response lands
        rd_v = 1'b0;
        step();
`ifdef IF_MISALIGN_CHECK_EN
        check_value("mis_fault", s_fault, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_value("mis_sticky", s_fault, 1'b1);
            check_value("mis_no_req", s_req, 1'b0);
        end
        do_reset(1'b0);
        step();
`else
        check_value("mis_addr", s_addr, 32'h100);
        check_value("mis_req", s_req, 1'b1);
        check_value("mis_nofault", s_fault, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", checks_run, checks_failed);
        $finish;
    end

endmodule
